// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 column shift register,
// presenting complete windows through a single-entry valid/ready output stage.
module sobel_window_gen #(
    parameter int nbit  = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [nbit-1:0] in_pixel,
    input  logic            in_valid,
    input  logic            in_sof,
    output logic            in_ready,
    output logic [nbit-1:0] P0,
    output logic [nbit-1:0] P1,
    output logic [nbit-1:0] P2,
    output logic [nbit-1:0] P3,
    output logic [nbit-1:0] P4,
    output logic [nbit-1:0] P5,
    output logic [nbit-1:0] P6,
    output logic [nbit-1:0] P7,
    output logic [nbit-1:0] P8,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_x,
    output logic [CW-1:0]   out_y,
    output logic            frame_done
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // Handshake: a beat moves on a port in any cycle where valid and ready are both
    // high at the rising edge; valid holds its data stable until that edge.
    logic [nbit-1:0] lb1 [IMG_W];
    logic [nbit-1:0] lb2 [IMG_W];
    logic [nbit-1:0] win [9];
    logic [CW-1:0]   col, row, cur_col, cur_row;
    logic [AW-1:0]   addr;
    logic [nbit-1:0] lb_top, lb_mid;
    logic            accept, emit;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel is placed at (0,0) regardless of where the counters were.
    assign cur_col = in_sof ? '0 : col;
    assign cur_row = in_sof ? '0 : row;
    assign emit    = accept && (cur_col >= CW'(2)) && (cur_row >= CW'(2));

    assign addr   = cur_col[AW-1:0];
    assign lb_top = lb2[addr];
    assign lb_mid = lb1[addr];

    // Line buffers are never reset; rows 0 and 1 of a frame refill them before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[addr] <= lb_mid;
            lb1[addr] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else begin
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= win[3*r+1];
                    win[3*r+1] <= win[3*r+2];
                end
                win[2] <= lb_top;
                win[5] <= lb_mid;
                win[8] <= in_pixel;
                if (cur_col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (cur_row == CW'(IMG_H - 1)) ? '0 : cur_row + CW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
                out_valid <= emit;
                if (emit) begin
                    out_x <= cur_col - CW'(1);
                    out_y <= cur_row - CW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign {P0, P1, P2} = {win[0], win[1], win[2]};
    assign {P3, P4, P5} = {win[3], win[4], win[5]};
    assign {P6, P7, P8} = {win[6], win[7], win[8]};

    // Pulses in the same cycle as the handshake of the frame's last window.
    assign frame_done = out_valid && out_ready &&
                        (out_x == CW'(IMG_W - 2)) && (out_y == CW'(IMG_H - 2));
endmodule
